// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage: PC, memory read handshake, instruction register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        instr_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fa;
    logic        fa_aligned;

    // A same-cycle pc_write redirects the fetch to the new target.
    assign fa         = pc_write ? pc_next : pc;
    assign fa_aligned = (fa[1:0] == 2'b00);

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign busy   = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fetch_start && fa_aligned) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            old_pc      <= 32'h0000_0000;
            instr       <= NOP_WORD;
            mem_addr    <= 32'h0000_0000;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_write) begin
                        pc <= pc_next;
                    end
                    if (fetch_start) begin
                        if (fa_aligned) begin
                            mem_addr <= fa;
                            mem_req  <= 1'b1;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        instr       <= mem_rdata;
                        old_pc      <= mem_addr;
                        pc          <= mem_addr + 32'd4;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
